// File: rtl/serial_1010_pkg.sv
// ---------------------------------------------------------------------------
// serial_1010_pkg
// Shared definitions for the 1010 framed-word transmitter and its matching
// Moore-style sequence detectors.
//
// Contents:
//   state_t     - transmitter FSM states (IDLE, HDR, DATA, GAP)
//   MARKER      - the 4-bit frame marker, sent MSB first
//   MARKER_LEN  - marker length in cycles
//   GUARD_LEN   - guard (GAP) cycles after each payload
//   marker_bit  - selects the marker bit for a 2-bit header index
// ---------------------------------------------------------------------------
package serial_1010_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HDR  = 2'b01,
        DATA = 2'b10,
        GAP  = 2'b11
    } state_t;

    localparam logic [3:0] MARKER     = 4'b1010;
    localparam int         MARKER_LEN = 4;
    localparam int         GUARD_LEN  = 1;

    // Index 0 must emit the marker MSB; inverting a 2-bit index gives 3-idx.
    function automatic logic marker_bit(input logic [1:0] idx);
        return MARKER[~idx];
    endfunction

endpackage

// File: rtl/serial_1010_tx_piso_shreg.sv
// ---------------------------------------------------------------------------
// piso_shreg
// Parallel-load, shift-left register whose MSB is the serial output.
// Load takes priority over shift.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-low; clears the register
//   load   - capture din
//   shift  - shift left by one, zero fill
//   din    - parallel word [WIDTH-1:0]
//   msb    - current MSB of the register
// ---------------------------------------------------------------------------
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] shreg;

    // Shift register body: load a fresh word or move the next bit into the MSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/serial_1010_tx.sv
// ---------------------------------------------------------------------------
// serial_1010_tx
// Framed-word serial transmitter. Accepts a word on valid/ready in IDLE, then
// sends an optional 1010 marker, the word MSB first, and one guard cycle.
// All outputs are decoded from state and registers only (Moore style).
//
// Configuration macro:
//   SERIAL_1010_TX_MARKER_EN - when defined every frame starts with 1010;
//                              when undefined the HDR state is never used.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous, active-low; aborts any frame in progress
//   data_in    - payload word [WIDTH-1:0], sampled on the handshake edge
//   valid      - requester has a word
//   ready      - block accepts a word (IDLE only)
//   dout       - serial data bit
//   dout_en    - dout carries a marker or payload bit
//   busy       - any state other than IDLE
//   frame_done - one-cycle pulse in the guard cycle
// ---------------------------------------------------------------------------
module serial_1010_tx
    import serial_1010_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             dout,
    output logic             dout_en,
    output logic             busy,
    output logic             frame_done
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             load_word;
    logic             shift_word;
    logic             shreg_msb;

`ifdef SERIAL_1010_TX_MARKER_EN
    logic [1:0]       hdr_idx;
`endif

    assign load_word  = (state == IDLE) && valid;
    assign shift_word = (state == DATA);

    piso_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (load_word),
        .shift (shift_word),
        .din   (data_in),
        .msb   (shreg_msb)
    );

    // State register; reset drops straight back to IDLE mid-frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Payload bit counter: loaded on the way into DATA, counts down to 0
    // on the last payload bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
        end else if ((state != DATA) && (state_nxt == DATA)) begin
            bit_cnt <= CNT_LOAD;
        end else if ((state == DATA) && (bit_cnt != '0)) begin
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

`ifdef SERIAL_1010_TX_MARKER_EN
    // Marker index: runs 0..3 through HDR and rests at 0 elsewhere, so every
    // frame starts its marker from the first bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_idx <= 2'd0;
        end else if (state == HDR) begin
            hdr_idx <= hdr_idx + 2'd1;
        end else begin
            hdr_idx <= 2'd0;
        end
    end
`endif

    // Next-state and Moore output decode. Anything not explicitly claimed
    // by a state (including an encoding this build never uses) falls back
    // to IDLE on the next edge.
    always_comb begin
        state_nxt  = IDLE;
        ready      = 1'b0;
        busy       = 1'b1;
        dout       = 1'b0;
        dout_en    = 1'b0;
        frame_done = 1'b0;

        case (state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (valid) begin
`ifdef SERIAL_1010_TX_MARKER_EN
                    state_nxt = HDR;
`else
                    state_nxt = DATA;
`endif
                end
            end

`ifdef SERIAL_1010_TX_MARKER_EN
            HDR: begin
                dout      = marker_bit(hdr_idx);
                dout_en   = 1'b1;
                state_nxt = (hdr_idx == 2'd3) ? DATA : HDR;
            end
`endif

            DATA: begin
                dout      = shreg_msb;
                dout_en   = 1'b1;
                state_nxt = (bit_cnt == '0) ? GAP : DATA;
            end

            GAP: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
